// File: rtl/pwm_sched_queue.sv
// pwm_sched_queue: FIFO of timed PWM duty updates, issued one at a time to the pwm unit
// as CMD_SCHEDULE_PWM, holding back a channel until its previously issued update has fired.
module pwm_sched_queue #(
  parameter int NPWM             = 12,
  parameter int CMD_BITS         = 8,
  parameter int CMD_SCHEDULE_PWM = 3,
  parameter int DEPTH            = 16,
  parameter int MIN_LEAD         = 8,
  localparam int CH_W            = $clog2(NPWM),
  localparam int LVL_W           = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         systime,
  input  logic                shutdown,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_channel,
  input  logic [31:0]         in_time,
  input  logic [25:0]         in_on_ticks,
  output logic [CMD_BITS-1:0] cmd,
  output logic                cmd_ready,
  output logic [31:0]         arg_data,
  input  logic                arg_advance,
  input  logic                cmd_done,
  output logic                late,
  output logic [15:0]         late_count,
  output logic [LVL_W-1:0]    level,
  output logic                busy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int PEND_N = 1 << CH_W;
  localparam logic signed [31:0] LEAD_MIN = MIN_LEAD;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t r_state, w_next;

  logic [CH_W-1:0]  r_memCh    [DEPTH];
  logic [31:0]      r_memTime  [DEPTH];
  logic [25:0]      r_memTicks [DEPTH];
  logic [PTR_W-1:0] r_wrPtr, r_rdPtr;
  logic [LVL_W-1:0] r_count;

  logic [PEND_N-1:0] r_pendFlag;
  logic [31:0]       r_pendTime [PEND_N];

  logic [CH_W-1:0] r_issCh;
  logic [31:0]     r_issTime;
  logic [25:0]     r_issTicks;
  logic [1:0]      r_argIdx;
  logic            r_abort;
  logic            r_late;
  logic [15:0]     r_lateCount;

  logic               w_full, w_empty, w_push, w_pop;
  logic               w_examine, w_headLate, w_drop, w_take, w_setPend;
  logic [CH_W-1:0]    w_headCh;
  logic [31:0]        w_headTime;
  logic [25:0]        w_headTicks;
  logic signed [31:0] w_lead;

  assign w_full      = (r_count == LVL_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign in_ready    = !w_full && !shutdown;
  assign w_push      = in_valid && in_ready;

  assign w_headCh    = r_memCh[r_rdPtr];
  assign w_headTime  = r_memTime[r_rdPtr];
  assign w_headTicks = r_memTicks[r_rdPtr];

  // Signed lead so a deadline already in the past reads as negative.
  assign w_lead      = signed'(w_headTime - systime);
  assign w_headLate  = (w_lead < LEAD_MIN);
  assign w_examine   = (r_state == S_IDLE) && !w_empty && !shutdown;
  assign w_drop      = w_examine && w_headLate;
  assign w_take      = w_examine && !w_headLate && !r_pendFlag[w_headCh];
  assign w_pop       = w_drop || w_take;
  assign w_setPend   = (r_state == S_WAIT) && cmd_done && !r_abort && !shutdown;

  always_ff @(posedge clk) begin
    if (rst || shutdown) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memCh[r_wrPtr]    <= in_channel;
      r_memTime[r_wrPtr]  <= in_time;
      r_memTicks[r_wrPtr] <= in_on_ticks;
    end
  end

  // A flag drops on the exact cycle pwm fires, so the next update may follow right behind it.
  always_ff @(posedge clk) begin
    if (rst || shutdown) begin
      r_pendFlag <= '0;
    end else begin
      for (int i = 0; i < PEND_N; i++) begin
        if (r_pendFlag[i] && (systime == r_pendTime[i])) r_pendFlag[i] <= 1'b0;
      end
      if (w_setPend) r_pendFlag[r_issCh] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_setPend) r_pendTime[r_issCh] <= r_issTime;
  end

  always_ff @(posedge clk) begin
    if (w_take) begin
      r_issCh    <= w_headCh;
      r_issTime  <= w_headTime;
      r_issTicks <= w_headTicks;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_argIdx <= 2'd0;
    end else if (w_take) begin
      r_argIdx <= 2'd0;
    end else if ((r_state == S_ISSUE) && arg_advance) begin
      r_argIdx <= r_argIdx + 2'd1;
    end
  end

  // A command caught by shutdown still finishes in pwm but must not leave a pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_abort <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_abort <= 1'b0;
    end else if (shutdown) begin
      r_abort <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_late      <= 1'b0;
      r_lateCount <= 16'd0;
    end else begin
      r_late <= w_drop;
      if (w_drop && (r_lateCount != 16'hFFFF)) r_lateCount <= r_lateCount + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_take) w_next = S_ISSUE;
      S_ISSUE: if (arg_advance && (r_argIdx == 2'd2)) w_next = S_WAIT;
      S_WAIT:  if (cmd_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    arg_data  = 32'd0;
    if (r_state == S_ISSUE) begin
      cmd_ready = 1'b1;
      case (r_argIdx)
        2'd0:    arg_data = 32'(r_issCh);
        2'd1:    arg_data = r_issTime;
        default: arg_data = 32'(r_issTicks);
      endcase
    end
  end

  assign cmd        = CMD_BITS'(CMD_SCHEDULE_PWM);
  assign late       = r_late;
  assign late_count = r_lateCount;
  assign level      = r_count;
  assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_pwm_sched_queue.sv
// tb_pwm_sched_queue: directed scoreboard bench; a monitor pops expected argument words
// and late pulses whenever the DUT presents them, with a small pwm responder model.
module tb_pwm_sched_queue;

  localparam int NPWM     = 12;
  localparam int CMD_BITS = 8;
  localparam int DEPTH    = 16;
  localparam int CH_W     = $clog2(NPWM);
  localparam int LVL_W    = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         systime;
  logic                shutdown;
  logic                in_valid;
  logic                in_ready;
  logic [CH_W-1:0]     in_channel;
  logic [31:0]         in_time;
  logic [25:0]         in_on_ticks;
  logic [CMD_BITS-1:0] cmd;
  logic                cmd_ready;
  logic [31:0]         arg_data;
  logic                arg_advance;
  logic                cmd_done;
  logic                late;
  logic [15:0]         late_count;
  logic [LVL_W-1:0]    level;
  logic                busy;

  typedef struct {
    logic [31:0] word;
    logic [31:0] notBefore;
    bit          first;
  } exp_t;

  exp_t        expQ[$];
  int          lateQ[$];
  int          testsRun  = 0;
  int          failures  = 0;
  int          lateModel = 0;
  logic [31:0] lastSched [16];
  bit          holdDone  = 1'b0;
  int          pwmCnt    = 0;
  int          pwmDly    = 0;

  pwm_sched_queue #(
    .NPWM(NPWM), .CMD_BITS(CMD_BITS), .CMD_SCHEDULE_PWM(3), .DEPTH(DEPTH), .MIN_LEAD(8)
  ) dut (
    .clk(clk), .rst(rst), .systime(systime), .shutdown(shutdown),
    .in_valid(in_valid), .in_ready(in_ready), .in_channel(in_channel),
    .in_time(in_time), .in_on_ticks(in_on_ticks), .cmd(cmd), .cmd_ready(cmd_ready),
    .arg_data(arg_data), .arg_advance(arg_advance), .cmd_done(cmd_done),
    .late(late), .late_count(late_count), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    systime = 32'd0;
    forever begin
      @(posedge clk);
      #1 systime = systime + 32'd1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // pwm model: consumes three arguments, then reports cmd_done two cycles later.
  initial begin
    cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      cmd_done = 1'b0;
      if (rst) begin
        pwmCnt = 0;
        pwmDly = 0;
      end else if (cmd_ready && arg_advance) begin
        pwmCnt++;
        if (pwmCnt == 3) begin
          pwmCnt = 0;
          if (!holdDone) pwmDly = 2;
        end
      end else if (pwmDly > 0) begin
        pwmDly--;
        if (pwmDly == 0) cmd_done = 1'b1;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cmd_ready && arg_advance) begin
          if (expQ.size() == 0) begin
            testsRun++;
            failures++;
            $display("[TB] FAIL unexpected_arg: got 0x%0h, expected no command", arg_data);
          end else begin
            e = expQ.pop_front();
            checkOutput("arg_data", arg_data, e.word);
            if (e.first) checkOutput("issue_after_pending", {31'd0, systime >= e.notBefore}, 32'd1);
          end
        end
        if (late) begin
          if (lateQ.size() == 0) begin
            testsRun++;
            failures++;
            $display("[TB] FAIL unexpected_late: got late=1, expected 0");
          end else begin
            checkOutput("late_count", 32'(late_count), 32'(lateQ.pop_front()));
          end
        end
      end
    end
  end

  // kind 0: expected to issue, 1: expected to be dropped late, 2: expected to be flushed
  task automatic applyStimulus(input int ch, input int off, input int ticks, input int kind);
    int          waited;
    bit          pushed;
    logic [31:0] tgt;
    waited = 0;
    pushed = 1'b0;
    tgt    = 32'd0;
    while (!pushed && waited <= 3000) begin
      @(negedge clk);
      tgt         = systime + 32'(off);
      in_channel  = CH_W'(ch);
      in_time     = tgt;
      in_on_ticks = 26'(ticks);
      in_valid    = 1'b1;
      if (in_ready) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
        pushed = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!pushed) begin
      in_valid = 1'b0;
      testsRun++;
      failures++;
      $display("[TB] FAIL push_timeout: ch %0d in_ready=%0b, expected 1", ch, in_ready);
    end else if (kind == 0) begin
      expQ.push_back('{32'(ch), lastSched[ch], 1'b1});
      expQ.push_back('{tgt, 32'd0, 1'b0});
      expQ.push_back('{32'(ticks), 32'd0, 1'b0});
      lastSched[ch] = tgt;
    end else if (kind == 1) begin
      lateModel++;
      lateQ.push_back(lateModel);
    end
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      testsRun++;
      failures++;
      $display("[TB] FAIL %s: busy=%0b after %0d cycles, expected 0", name, busy, n);
    end
  endtask

  task automatic waitPast(input int budget);
    logic [31:0] maxT;
    int          n;
    maxT = 32'd0;
    n    = 0;
    for (int i = 0; i < 16; i++) if (lastSched[i] > maxT) maxT = lastSched[i];
    while (systime <= maxT + 32'd2 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic issueQuick(input int ch, input int off, input int ticks, input string name);
    applyStimulus(ch, off, ticks, 0);
    @(negedge clk);
    checkOutput({name, "_level"}, 32'(level), 32'd1);
    checkOutput({name, "_ready_n1"}, 32'(cmd_ready), 32'd0);
    @(negedge clk);
    checkOutput({name, "_ready_n2"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic clearSched();
    for (int i = 0; i < 16; i++) lastSched[i] = 32'd0;
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    shutdown    = 1'b0;
    in_valid    = 1'b0;
    in_channel  = '0;
    in_time     = 32'd0;
    in_on_ticks = 26'd0;
    arg_advance = 1'b1;
    clearSched();

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_arg_data", arg_data, 32'd0);
    checkOutput("rst_late", 32'(late), 32'd0);
    checkOutput("rst_late_count", 32'(late_count), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("cmd_code", 32'(cmd), 32'd3);
    rst = 1'b0;

    $display("[TB] single entry ch3 and follow-up on same channel");
    issueQuick(3, 100, 'h1234, "t1");
    applyStimulus(3, 150, 'h55, 0);
    waitIdle(400, "t1_idle");

    $display("[TB] two entries for ch5");
    applyStimulus(5, 20, 'h20, 0);
    applyStimulus(5, 40, 'h40, 0);
    waitIdle(200, "t2_idle");

    $display("[TB] late entry then normal entry");
    applyStimulus(7, 2, 'h7, 1);
    applyStimulus(8, 60, 'h8, 0);
    waitIdle(200, "t3_idle");

    $display("[TB] push and pop on the same edge");
    applyStimulus(9, 100, 'h9, 0);
    applyStimulus(10, 100, 'hA, 0);
    @(negedge clk);
    checkOutput("t4_level_pushpop", 32'(level), 32'd1);
    waitIdle(300, "t4_idle");

    $display("[TB] fill and wrap over 40 entries");
    applyStimulus(0, 300, 'h11, 0);
    waitIdle(100, "t5_blocker");
    for (int k = 0; k < 40; k++) begin
      if (k == 16) begin
        @(negedge clk);
        checkOutput("t5_full_level", 32'(level), 32'd16);
        checkOutput("t5_full_in_ready", 32'(in_ready), 32'd0);
      end
      applyStimulus(k % 12, 600 + 30 * k, 'h100 + k, 0);
    end
    waitIdle(8000, "t5_drain");
    waitPast(3000);

    $display("[TB] shutdown during issue");
    applyStimulus(6, 500, 'h66, 0);
    waitIdle(100, "t6_ch6");
    @(posedge clk);
    #1 arg_advance = 1'b0;
    applyStimulus(2, 200, 'h22, 0);
    applyStimulus(4, 300, 'h44, 2);
    applyStimulus(7, 300, 'h77, 2);
    applyStimulus(8, 300, 'h88, 2);
    applyStimulus(9, 300, 'h99, 2);
    @(negedge clk);
    checkOutput("t6_level_queued", 32'(level), 32'd4);
    checkOutput("t6_in_issue", 32'(cmd_ready), 32'd1);
    shutdown = 1'b1;
    #1;
    checkOutput("t6_sd_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("t6_sd_level", 32'(level), 32'd0);
    clearSched();
    @(posedge clk);
    #1 arg_advance = 1'b1;
    waitIdle(100, "t6_complete");
    checkOutput("t6_sd_in_ready_held", 32'(in_ready), 32'd0);
    checkOutput("t6_sd_level_held", 32'(level), 32'd0);
    @(negedge clk);
    shutdown = 1'b0;
    #1;
    checkOutput("t6_in_ready_back", 32'(in_ready), 32'd1);
    issueQuick(2, 100, 'h33, "t6_ch2_free");
    waitIdle(100, "t6_ch2_idle");
    issueQuick(6, 100, 'h67, "t6_ch6_free");
    waitIdle(100, "t6_ch6_idle");

    $display("[TB] reset while waiting for cmd_done");
    holdDone = 1'b1;
    applyStimulus(11, 200, 'h2AB, 0);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t7_issue_seen", 32'(cmd_ready), 32'd1);
    n = 0;
    while (cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t7_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t7_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("t7_arg_data", arg_data, 32'd0);
    checkOutput("t7_late", 32'(late), 32'd0);
    checkOutput("t7_late_count", 32'(late_count), 32'd0);
    checkOutput("t7_level", 32'(level), 32'd0);
    checkOutput("t7_busy", 32'(busy), 32'd0);
    checkOutput("t7_in_ready", 32'(in_ready), 32'd1);
    rst       = 1'b0;
    holdDone  = 1'b0;
    lateModel = 0;
    clearSched();

    repeat (4) @(negedge clk);
    checkOutput("end_exp_args_left", 32'(expQ.size()), 32'd0);
    checkOutput("end_exp_late_left", 32'(lateQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/pwm_sched_queue.md
# pwm_sched_queue

Buffers timed PWM duty-cycle updates from the host command path and issues them one at a time to the `pwm` unit as `CMD_SCHEDULE_PWM` commands over the standard `cmd`/`arg_data` handshake. The `pwm` unit holds only one pending schedule per channel, so this block withholds a channel's next update until the previous one has fired. It also drops entries whose deadline can no longer be met, and flushes everything on shutdown.

## Interface
- `NPWM`, 12, number of PWM channels
- `CMD_BITS`, 8, width of `cmd`
- `CMD_SCHEDULE_PWM`, 3, command code driven on `cmd`
- `DEPTH`, 16, queue entries (power of two)
- `MIN_LEAD`, 8, minimum clocks between issue decision and target time

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `systime`  in  32  free-running system time, +1 per clock
- `shutdown`  in  1  global shutdown
- `in_valid`  in  1  enqueue request
- `in_ready`  out  1  queue accepts entry (`!full && !shutdown`)
- `in_channel`  in  $clog2(NPWM)  target channel
- `in_time`  in  32  systime at which the new value takes effect
- `in_on_ticks`  in  26  on_ticks value for `pwm`
- `cmd`  out  CMD_BITS  constant `CMD_SCHEDULE_PWM`
- `cmd_ready`  out  1  command presented to `pwm`
- `arg_data`  out  32  current argument word
- `arg_advance`  in  1  `pwm` consumed current argument
- `cmd_done`  in  1  `pwm` finished command
- `late`  out  1  one-cycle pulse: head entry dropped as late
- `late_count`  out  16  saturating count of dropped entries
- `level`  out  $clog2(DEPTH+1)  entries in queue
- `busy`  out  1  FSM not in IDLE or queue non-empty

## Operation
- Reset: `in_ready`=1, `cmd_ready`=0, `arg_data`=0, `late`=0, `late_count`=0, `level`=0, `busy`=0. Queue is empty, all pending flags are cleared, FSM is IDLE.
- Queue: synchronous FIFO of {channel, time, on_ticks}.
  - Push when `in_valid && in_ready`.
  - Push and pop in the same cycle are both honoured; `level` is unchanged.
- Pending table: one flag plus one 32-bit time per channel.
  - A flag is set with the issued time when `cmd_done` is seen.
  - A flag clears when `systime == pending_time[ch]`, matching `pwm`'s firing condition.
- FSM:
  - IDLE, queue non-empty, head examined:
    - `lead = head.time - systime`, evaluated as 32-bit signed.
    - If `lead < MIN_LEAD`: pop, pulse `late`, increment `late_count` (saturating at 0xFFFF), stay IDLE.
    - Otherwise, if `pending[head.channel]` is set: stay IDLE. This is head-of-line blocking by design; entries for other channels wait.
    - Otherwise: pop, latch the entry into issue registers, go to ISSUE with `arg_idx`=0.
  - ISSUE: `cmd_ready`=1, `arg_data` = {zero-extended channel, time, zero-extended on_ticks}[`arg_idx`].
    - Each clock with `arg_advance`=1 increments `arg_idx`.
    - When arg 2 is consumed, go to WAIT_DONE.
  - WAIT_DONE: `cmd_ready`=0. On `cmd_done`, set `pending[ch]`, go to IDLE.
- Shutdown (level-sensitive):
  - Flush the queue and clear all pending flags every cycle `shutdown` is high; `in_ready`=0.
  - A command already in ISSUE/WAIT_DONE runs to completion, because the `pwm` FSM cannot be aborted. Its pending flag is not set.
  - No new issue while `shutdown` is high.
- `rst` mid-command: immediate return to the reset state. `cmd_ready` drops on the next clock.

## Timing
- Push into an empty queue at edge N, FSM IDLE and channel free: head is examined in cycle N+1, `cmd_ready` is high from N+2.
- With `arg_advance` held high, `cmd_ready` is high for exactly 3 cycles carrying channel, time, on_ticks in that order. It is low in the cycle `pwm` returns to idle with `cmd_done`=1, so no spurious reissue occurs.
- Back-to-back issues to different channels: minimum 6 cycles apart.
- A pending flag set and cleared in the same cycle is impossible, because `MIN_LEAD` exceeds issue latency.
- The simultaneous clear of one channel and set of another are both honoured.

## Test plan
- Single entry (ch 3, time = systime+100, on_ticks 0x1234) → `cmd_ready` 3 cycles with args 3, time, 0x1234; `pending[3]` set on `cmd_done`, cleared at the target time.
- Two entries for ch 5 (times +20, +40) → second issued only after systime reaches +20; no overlapping `cmd_ready`.
- Entry with time = systime+2 → `late` pulse, `late_count`=1, no `cmd_ready`; the next queued entry issues normally.
- Fill 16 entries → `in_ready`=0, `level`=16; simultaneous push+pop when not full keeps `level` constant; wrap-around preserves order over 40 entries.
- `shutdown` during ISSUE with 4 queued → current command completes, queue empties, all pending cleared, `in_ready`=0 until `shutdown` drops.
- `rst` asserted in WAIT_DONE → all outputs at reset values the next cycle; `late_count`=0.
